audio_tdm_tx: RTL and testbench

- Parametrised successor to the fixed 2-channel, 16-bit codec driver.
- Generates BCK and LRCK from the 18.432 MHz reference and serialises CHANNEL_NUM channels of DATA_WIDTH-bit samples, MSB first, in I2S or left-justified format.
- Samples arrive from the tone/beep generator over a valid/ready handshake, one frame (all channels) per transfer.
- Adds:
  - single-clock operation (BCK is a register, never a clock);
  - frame buffering;
  - underrun detection;
  - frame-aligned mute.

---
 rtl/audio_tdm_tx.sv | 122 ++++++++++++
 tb/tb_audio_tdm_tx.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/audio_tdm_tx.sv
// TDM/I2S serial audio transmitter: derives BCK/LRCK from the reference clock
// as ordinary registers and shifts out one buffered multi-channel frame per LRCK period.
module audio_tdm_tx #(
    parameter int REF_CLK          = 18432000,
    parameter int SAMPLE_RATE      = 48000,
    parameter int DATA_WIDTH       = 16,
    parameter int CHANNEL_NUM      = 2,
    parameter int JUSTIFY          = 0,
    parameter int ZERO_ON_UNDERRUN = 1
) (
    input  logic                              iCLK_18_4,
    input  logic                              iRST_N,
    input  logic [CHANNEL_NUM*DATA_WIDTH-1:0] iSAMPLE,
    input  logic                              iVALID,
    output logic                              oREADY,
    input  logic                              iMUTE,
    output logic                              oAUD_BCK,
    output logic                              oAUD_LRCK,
    output logic                              oAUD_DATA,
    output logic                              oFRAME_START,
    output logic                              oUNDERRUN
);
    localparam int FRAME_BITS = DATA_WIDTH * CHANNEL_NUM;
    localparam int BCK_HALF   = REF_CLK / (SAMPLE_RATE * FRAME_BITS * 2);
    localparam int DIV_W      = (BCK_HALF > 1) ? $clog2(BCK_HALF) : 1;
    localparam int P_W        = $clog2(FRAME_BITS);

    if (BCK_HALF < 1) begin : g_bad_ratio
        $error("audio_tdm_tx: REF_CLK too low for the requested bit clock");
    end

    logic [DIV_W-1:0]      div_q;
    logic [DIV_W-1:0]      div_d;
    logic                  bck_d;
    logic [P_W-1:0]        p_q;
    logic [P_W-1:0]        p_d;
    logic [P_W-1:0]        idx;
    logic [FRAME_BITS-1:0] frame_q;
    logic [FRAME_BITS-1:0] frame_d;
    logic [FRAME_BITS-1:0] hold_q;
    logic                  hold_full_q;
    logic                  hold_full_d;
    logic                  tc;
    logic                  fall;
    logic                  load;
    logic                  load_soon;
    logic                  xfer;
    logic                  lj_bit;
    logic                  lrck_d;
    logic                  dly_q;
    int                    sel;

    always_comb begin
        tc      = (div_q == DIV_W'(BCK_HALF - 1));
        div_d   = tc ? '0 : div_q + 1'b1;
        bck_d   = tc ? ~oAUD_BCK : oAUD_BCK;
        fall    = tc && oAUD_BCK;
        load    = fall && (p_q == P_W'(FRAME_BITS - 1));
        p_d     = p_q;
        if (fall) begin
            p_d = (p_q == P_W'(FRAME_BITS - 1)) ? '0 : p_q + 1'b1;
        end
        xfer    = iVALID && oREADY;

        // Mute wins over both the fresh frame and the underrun policy
        frame_d = frame_q;
        if (load) begin
            if (iMUTE) begin
                frame_d = '0;
            end else if (hold_full_q) begin
                frame_d = hold_q;
            end else if (ZERO_ON_UNDERRUN != 0) begin
                frame_d = '0;
            end
        end

        hold_full_d = (hold_full_q && !load) || xfer;
        // Raise READY one cycle early so a new frame can be taken in the very load cycle
        load_soon   = (div_d == DIV_W'(BCK_HALF - 1)) && bck_d
                      && (p_d == P_W'(FRAME_BITS - 1));

        sel    = int'(p_d);
        idx    = P_W'((sel / DATA_WIDTH) * DATA_WIDTH + DATA_WIDTH - 1 - (sel % DATA_WIDTH));
        lj_bit = frame_d[idx];
        lrck_d = (p_d >= P_W'(FRAME_BITS / 2));
    end

    always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
        if (!iRST_N) begin
            div_q        <= '0;
            oAUD_BCK     <= 1'b0;
            p_q          <= P_W'(FRAME_BITS - 1);
            frame_q      <= '0;
            hold_q       <= '0;
            hold_full_q  <= 1'b0;
            dly_q        <= 1'b0;
            oREADY       <= 1'b1;
            oAUD_LRCK    <= 1'b0;
            oAUD_DATA    <= 1'b0;
            oFRAME_START <= 1'b0;
            oUNDERRUN    <= 1'b0;
        end else begin
            div_q        <= div_d;
            oAUD_BCK     <= bck_d;
            p_q          <= p_d;
            frame_q      <= frame_d;
            hold_full_q  <= hold_full_d;
            if (xfer) begin
                hold_q <= iSAMPLE;
            end
            oREADY       <= !hold_full_d || load_soon;
            oFRAME_START <= load;
            oUNDERRUN    <= load && !hold_full_q;
            // Serial outputs change only together with the BCK falling edge
            if (fall) begin
                oAUD_LRCK <= lrck_d;
                dly_q     <= lj_bit;
                oAUD_DATA <= (JUSTIFY != 0) ? lj_bit : dly_q;
            end
        end
    end
endmodule

// File: tb/tb_audio_tdm_tx.sv
// Directed bench for audio_tdm_tx: default I2S instance plus a 4x24-bit
// left-justified instance that repeats frames on underrun.
module tb_audio_tdm_tx;
    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- instance A: defaults, I2S, zeros on underrun
    logic        a_rst, a_valid, a_ready, a_mute, a_bck, a_lrck, a_data, a_fs, a_ur;
    logic [31:0] a_sample;
    int          cyc_a;

    audio_tdm_tx dut_a (
        .iCLK_18_4(clk), .iRST_N(a_rst), .iSAMPLE(a_sample), .iVALID(a_valid),
        .oREADY(a_ready), .iMUTE(a_mute), .oAUD_BCK(a_bck), .oAUD_LRCK(a_lrck),
        .oAUD_DATA(a_data), .oFRAME_START(a_fs), .oUNDERRUN(a_ur)
    );

    // ---------------- instance B: 4 x 24 bit, left-justified, repeat on underrun
    logic        b_rst, b_valid, b_ready, b_mute, b_bck, b_lrck, b_data, b_fs, b_ur;
    logic [95:0] b_sample;
    int          cyc_b;

    audio_tdm_tx #(
        .DATA_WIDTH(24), .CHANNEL_NUM(4), .JUSTIFY(1), .ZERO_ON_UNDERRUN(0)
    ) dut_b (
        .iCLK_18_4(clk), .iRST_N(b_rst), .iSAMPLE(b_sample), .iVALID(b_valid),
        .oREADY(b_ready), .iMUTE(b_mute), .oAUD_BCK(b_bck), .oAUD_LRCK(b_lrck),
        .oAUD_DATA(b_data), .oFRAME_START(b_fs), .oUNDERRUN(b_ur)
    );

    always @(posedge clk or negedge a_rst) if (!a_rst) cyc_a <= 0; else cyc_a <= cyc_a + 1;
    always @(posedge clk or negedge b_rst) if (!b_rst) cyc_b <= 0; else cyc_b <= cyc_b + 1;

    // Serial capture: bits sampled at BCK rise; entry k holds the frame before load k
    logic [31:0] a_sh = '0, a_lsh = '0;
    logic        a_bq = 1'b0;
    logic [31:0] a_frames[$];
    logic [31:0] a_lrs[$];
    logic        a_urs[$];
    int          a_fsc[$];
    logic [95:0] b_sh = '0, b_lsh = '0;
    logic        b_bq = 1'b0;
    logic [95:0] b_frames[$];
    logic [95:0] b_lrs[$];
    logic        b_urs[$];
    int          b_fsc[$];

    always @(posedge clk) begin
        #1;
        if (a_fs === 1'b1) begin
            a_frames.push_back(a_sh); a_lrs.push_back(a_lsh);
            a_urs.push_back(a_ur);    a_fsc.push_back(cyc_a);
        end
        if (a_bck && !a_bq) begin
            a_sh = {a_sh[30:0], a_data}; a_lsh = {a_lsh[30:0], a_lrck};
        end
        a_bq = a_bck;
        if (b_fs === 1'b1) begin
            b_frames.push_back(b_sh); b_lrs.push_back(b_lsh);
            b_urs.push_back(b_ur);    b_fsc.push_back(cyc_b);
        end
        if (b_bck && !b_bq) begin
            b_sh = {b_sh[94:0], b_data}; b_lsh = {b_lsh[94:0], b_lrck};
        end
        b_bq = b_bck;
    end

    function automatic logic [31:0] dval(int n);
        return {16'h3A00 + 16'(n * 7), 16'h9100 + 16'(n * 3)};
    endfunction

    localparam logic [95:0] FRAME_A  = {24'hC0FFEE, 24'h123456, 24'hABCDEF, 24'h800001};
    localparam logic [95:0] STREAM_A = {24'h800001, 24'hABCDEF, 24'h123456, 24'hC0FFEE};
    localparam logic [95:0] LR_B     = {48'h0, {48{1'b1}}};

    initial begin
        logic [31:0] s, s_prev, exp_w;
        int nx, bad, guard, base, sz0;
        logic found;

        a_rst = 1'b0; a_valid = 1'b0; a_mute = 1'b0; a_sample = '0;
        b_rst = 1'b0; b_valid = 1'b0; b_mute = 1'b0; b_sample = '0;
        tick(); tick();
        chk("rst_bck", a_bck, 1'b0);
        chk("rst_lrck", a_lrck, 1'b0);
        chk("rst_data", a_data, 1'b0);
        chk("rst_ready", a_ready, 1'b1);
        chk("rst_fs", a_fs, 1'b0);
        chk("rst_ur", a_ur, 1'b0);

        // A: one frame offered before the first load
        a_rst = 1'b1; a_valid = 1'b1; a_sample = 32'h1234_A5C3;
        tick();
        a_valid = 1'b0;
        chk("a_ready_after_xfer", a_ready, 1'b0);
        while (cyc_a < 6) tick();
        chk("a_bck_rise6", a_bck, 1'b1);
        while (cyc_a < 11) tick();
        chk("a_bck_11", a_bck, 1'b1);
        chk("a_fs_11", a_fs, 1'b0);
        tick();
        chk("a_bck_fall12", a_bck, 1'b0);
        chk("a_fs_12", a_fs, 1'b1);
        chk("a_ur_12", a_ur, 1'b0);

        guard = 0;
        while (a_frames.size() < 3 && guard < 2000) begin tick(); guard++; end
        chk("a_wait_frames", a_frames.size() >= 3, 1'b1);
        chk("a_first_load_cyc", a_fsc[0], 12);
        chk("a_frame_period", a_fsc[2] - a_fsc[1], 384);
        chk("a_i2s_frame0", a_frames[1], 32'h52E1_891A);
        chk("a_lrck_frame0", a_lrs[1], 32'h0000_FFFF);
        chk("a_ur_load1", a_urs[1], 1'b1);
        chk("a_i2s_frame1_zero", a_frames[2], 32'h0);
        chk("a_lrck_frame1", a_lrs[2], 32'h0000_FFFF);
        chk("a_ur_load2", a_urs[2], 1'b1);

        // A: backpressure, VALID held high with a new sample after each transfer
        while (cyc_a < 800) tick();
        nx = 0; bad = 0; guard = 0;
        a_sample = dval(0); a_valid = 1'b1;
        while (a_frames.size() < 14 && guard < 6000) begin
            logic will;
            will = a_valid && a_ready;
            tick(); guard++;
            if (will) begin
                if (nx > 0 && !a_fs) bad++;
                nx++;
                if (nx == 1) chk("bp_ready_low", a_ready, 1'b0);
                a_sample = dval(nx);
            end
        end
        a_valid = 1'b0;
        chk("bp_wait", a_frames.size() >= 14, 1'b1);
        chk("bp_xfer_at_load", bad, 0);
        chk("bp_xfer_count", nx, 12);
        s_prev = '0;
        for (int n = 0; n < 10; n++) begin
            s = {dval(n)[15:0], dval(n)[31:16]};
            exp_w = {s_prev[0], s[31:1]};
            chk($sformatf("bp_frame%0d", n), a_frames[4 + n], exp_w);
            chk($sformatf("bp_ur%0d", n), a_urs[3 + n], 1'b0);
            s_prev = s;
        end

        // B: frame A then starvation, mute at load 3
        b_rst = 1'b1; b_valid = 1'b1; b_sample = FRAME_A;
        tick();
        b_valid = 1'b0;
        while (cyc_b < 1100) tick();
        b_mute = 1'b1;
        while (cyc_b < 1200) tick();
        b_mute = 1'b0;
        while (cyc_b < 1300) tick();
        b_valid = 1'b1;
        tick();
        b_valid = 1'b0;
        guard = 0;
        while (b_frames.size() < 5 && guard < 1000) begin tick(); guard++; end
        chk("b_wait_frames", b_frames.size() >= 5, 1'b1);
        chk("b_first_load_cyc", b_fsc[0], 4);
        chk("b_ur_load0", b_urs[0], 1'b0);
        chk("b_lj_frame0", b_frames[1], STREAM_A);
        chk("b_lrck_frame0", b_lrs[1], LR_B);
        chk("b_repeat_frame1", b_frames[2], STREAM_A);
        chk("b_ur_load1", b_urs[1], 1'b1);
        chk("b_repeat_frame2", b_frames[3], STREAM_A);
        chk("b_ur_load2", b_urs[2], 1'b1);
        chk("b_mute_frame3", b_frames[4], 96'h0);
        chk("b_ur_load3", b_urs[3], 1'b1);
        chk("b_ur_load4", b_urs[4], 1'b0);

        // B: fill the holding register, then reset mid-frame with outputs high
        while (cyc_b < 1560) tick();
        b_valid = 1'b1; b_sample = 96'h5;
        tick();
        b_valid = 1'b0;
        while (cyc_b < 1800) tick();
        found = 1'b0; guard = 0;
        while (!found && guard < 100) begin
            if (b_bck && b_data && b_lrck) found = 1'b1;
            else begin tick(); guard++; end
        end
        chk("b_pre_reset_high", found, 1'b1);
        #2 b_rst = 1'b0;
        #1;
        chk("b_mid_rst_bck", b_bck, 1'b0);
        chk("b_mid_rst_lrck", b_lrck, 1'b0);
        chk("b_mid_rst_data", b_data, 1'b0);
        chk("b_mid_rst_ready", b_ready, 1'b1);
        chk("b_mid_rst_fs", b_fs, 1'b0);
        chk("b_mid_rst_ur", b_ur, 1'b0);
        tick(); tick();
        sz0 = b_frames.size();
        b_rst = 1'b1;
        tick();
        chk("b_re_bck1", b_bck, 1'b0);
        tick();
        chk("b_re_bck2", b_bck, 1'b1);
        tick(); tick();
        chk("b_re_fall4", b_bck, 1'b0);
        chk("b_re_fs4", b_fs, 1'b1);
        chk("b_re_ur4", b_ur, 1'b1);
        guard = 0;
        while (b_frames.size() < sz0 + 2 && guard < 1000) begin tick(); guard++; end
        chk("b_re_wait", b_frames.size() >= sz0 + 2, 1'b1);
        base = b_fsc[sz0];
        chk("b_re_load_cyc", base, 4);
        chk("b_re_period", b_fsc[sz0 + 1] - base, 384);
        chk("b_re_frame_zero", b_frames[sz0 + 1], 96'h0);
        chk("b_re_lrck", b_lrs[sz0 + 1], LR_B);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
